gem_link_sequencer: RTL and testbench

Bring-up controller and frame scheduler for the GEM trigger fiber transmitter. Sequences GTX TX PLL reset, GTX TX reset, phase-sync wait and comma fill. Once the link is up, schedules buffered GEM cluster words into 2-cycle fiber frames. Drives the GEM_DATA / FRM_SEP / GEM_OVERFLOW inputs and the reset controls of `gem_fiber_out`.

---
 rtl/gem_link_pkg.sv | 33 +++
 rtl/gem_clu_fifo.sv | 73 +++++++
 rtl/gem_link_sequencer.sv | 153 +++++++++++++++
 tb/tb_gem_link_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gem_link_pkg.sv
// rtl/gem_link_pkg.sv - shared types and constants for the GEM link sequencer
// Purpose: FSM state encoding, K-code constants, K-rotation table, cluster width.
// Ports:   none (package).
package gem_link_pkg;

   localparam int CLU_W = 56;

   typedef enum logic [2:0] {
      S_PLLRST    = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_GTXRST    = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_COMMA     = 3'd4,
      S_RUN       = 3'd5
   } state_t;

   localparam logic [7:0] K_BC = 8'hBC;
   localparam logic [7:0] K_F7 = 8'hF7;
   localparam logic [7:0] K_FB = 8'hFB;
   localparam logic [7:0] K_FD = 8'hFD;
   localparam logic [7:0] K_FC = 8'hFC;

   // Frame separator rotation: BC, F7, FB, FD, then wraps.
   function automatic logic [7:0] k_rot(input logic [1:0] idx);
      case (idx)
         2'd0:    return K_BC;
         2'd1:    return K_F7;
         2'd2:    return K_FB;
         default: return K_FD;
      endcase
   endfunction

endpackage

// File: rtl/gem_clu_fifo.sv
// rtl/gem_clu_fifo.sv - cluster word FIFO with synchronous flush
// Purpose: 2^FIFO_AW deep buffer between cluster finder and frame scheduler.
// Ports:   clk, rst (async, active-high), flush (clears contents),
//          push/din (write), pop (read, advances head), head (current word),
//          full/empty (registered status).
module gem_clu_fifo #(
   parameter int FIFO_AW = 2,
   parameter int W       = 56
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int DEPTH = 1 << FIFO_AW;

   logic [W-1:0]       mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [FIFO_AW:0]   count_nxt;
   logic               do_push;
   logic               do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         count <= count_nxt;
         full  <= (count_nxt == (FIFO_AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage needs no reset: head is only consumed when empty is low.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/gem_link_sequencer.sv
// rtl/gem_link_sequencer.sv - GTX bring-up sequencer and GEM frame scheduler
// Purpose: sequences PLL reset, TX reset, sync wait and comma fill, then packs
//          buffered cluster words into 2-cycle fiber frames.
// Ports:   TRG_CLK80/RST clock and async reset; TX_PLL_LOCK, TXRESETDONE,
//          TX_SYNC_DONE status in; TRG_TX_PLLRST, TRG_GTXTXRST, TRG_RST reset
//          controls out; CLU_DATA/CLU_VALID/CLU_READY cluster input;
//          GEM_DATA, FRM_SEP, GEM_OVERFLOW frame out; LINK_UP, STATE, ERR_CNT status.
import gem_link_pkg::*;

module gem_link_sequencer #(
   parameter int PLLRST_CYC  = 8,
   parameter int GTXRST_CYC  = 8,
   parameter int COMMA_CYC   = 64,
   parameter int TIMEOUT_CYC = 65535,
   parameter int FIFO_AW     = 2
) (
   input  logic             TRG_CLK80,
   input  logic             RST,
   input  logic             TX_PLL_LOCK,
   input  logic             TXRESETDONE,
   input  logic             TX_SYNC_DONE,
   output logic             TRG_TX_PLLRST,
   output logic             TRG_GTXTXRST,
   output logic             TRG_RST,
   input  logic [CLU_W-1:0] CLU_DATA,
   input  logic             CLU_VALID,
   output logic             CLU_READY,
   output logic [CLU_W-1:0] GEM_DATA,
   output logic [7:0]       FRM_SEP,
   output logic             GEM_OVERFLOW,
   output logic             LINK_UP,
   output logic [2:0]       STATE,
   output logic [7:0]       ERR_CNT
);
   // Dwell counts 0..N-1, so the transition fires on the last held cycle.
   localparam logic [15:0] PLL_LAST   = 16'(PLLRST_CYC - 1);
   localparam logic [15:0] GTX_LAST   = 16'(GTXRST_CYC - 1);
   localparam logic [15:0] COMMA_LAST = 16'(COMMA_CYC - 1);
   localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);

   state_t           state, state_nxt;
   logic [15:0]      dwell;
   logic             err_inc;
   logic             lock_loss;
   logic             in_run, flush, boundary;
   logic             ph;
   logic [1:0]       kidx;
   logic             ovf_acc, ovf_evt;
   logic             fifo_full, fifo_empty;
   logic [CLU_W-1:0] fifo_head;

   assign STATE = state;

   always_comb begin
      state_nxt = state;
      err_inc   = 1'b0;
      lock_loss = !TX_PLL_LOCK &&
                  (state inside {S_GTXRST, S_WAIT_DONE, S_COMMA, S_RUN});
      if (lock_loss) begin
         state_nxt = S_PLLRST;
         err_inc   = 1'b1;
      end else begin
         case (state)
            S_PLLRST:    if (dwell == PLL_LAST) state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: if (TX_PLL_LOCK) state_nxt = S_GTXRST;
                         else if (dwell == TO_LAST) begin
                            state_nxt = S_PLLRST;
                            err_inc   = 1'b1;
                         end
            S_GTXRST:    if (dwell == GTX_LAST) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (TXRESETDONE && TX_SYNC_DONE) state_nxt = S_COMMA;
                         else if (dwell == TO_LAST) begin
                            state_nxt = S_PLLRST;
                            err_inc   = 1'b1;
                         end
            S_COMMA:     if (dwell == COMMA_LAST) state_nxt = S_RUN;
            S_RUN:       state_nxt = S_RUN;
            default:     state_nxt = S_PLLRST;
         endcase
      end
   end

   // Controls are decoded from the next state so they switch with STATE.
   always_ff @(posedge TRG_CLK80 or posedge RST) begin
      if (RST) begin
         state         <= S_PLLRST;
         dwell         <= '0;
         ERR_CNT       <= '0;
         TRG_TX_PLLRST <= 1'b1;
         TRG_GTXTXRST  <= 1'b1;
         TRG_RST       <= 1'b1;
         LINK_UP       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) dwell <= '0;
         else if (state != S_RUN) dwell <= dwell + 1'b1;
         if (err_inc && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 1'b1;
         TRG_TX_PLLRST <= (state_nxt == S_PLLRST);
         TRG_GTXTXRST  <= (state_nxt inside {S_PLLRST, S_WAIT_LOCK, S_GTXRST});
         TRG_RST       <= (state_nxt != S_RUN);
         LINK_UP       <= (state_nxt == S_RUN);
      end
   end

   assign in_run    = (state == S_RUN);
   assign flush     = (state_nxt != S_RUN);
   assign boundary  = in_run && ph;
   assign CLU_READY = in_run && !fifo_full;
   assign ovf_evt   = in_run && CLU_VALID && !CLU_READY;

   gem_clu_fifo #(.FIFO_AW(FIFO_AW), .W(CLU_W)) u_fifo (
      .clk   (TRG_CLK80),
      .rst   (RST),
      .flush (flush),
      .push  (CLU_VALID && CLU_READY),
      .din   (CLU_DATA),
      .pop   (boundary),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge TRG_CLK80 or posedge RST) begin
      if (RST) begin
         ph           <= 1'b0;
         kidx         <= '0;
         ovf_acc      <= 1'b0;
         GEM_DATA     <= '0;
         FRM_SEP      <= K_BC;
         GEM_OVERFLOW <= 1'b0;
      end else if (flush) begin
         ph           <= 1'b0;
         kidx         <= '0;
         ovf_acc      <= 1'b0;
         GEM_DATA     <= '0;
         FRM_SEP      <= K_BC;
         GEM_OVERFLOW <= 1'b0;
      end else if (in_run) begin
         ph <= ~ph;
         if (boundary) begin
            GEM_DATA     <= fifo_empty ? '0 : fifo_head;
            FRM_SEP      <= k_rot(kidx);
            kidx         <= kidx + 1'b1;
            // The boundary cycle itself still belongs to the ending frame.
            GEM_OVERFLOW <= ovf_acc | ovf_evt;
            ovf_acc      <= 1'b0;
         end else begin
            ovf_acc <= ovf_acc | ovf_evt;
         end
      end
   end

endmodule

// File: tb/tb_gem_link_sequencer.sv
// tb/tb_gem_link_sequencer.sv - randomized self-checking bench for gem_link_sequencer
module tb_gem_link_sequencer;

   localparam int P_PLL = 8, P_GTX = 8, P_COMMA = 64, P_TO = 16, DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, lock, done, sync, clu_valid;
   logic [55:0] clu_data;
   logic        pllrst, gtxrst, trg_rst, clu_ready, gem_ovf, link_up;
   logic [55:0] gem_data;
   logic [7:0]  frm_sep, err_cnt;
   logic [2:0]  state;

   always #6 clk = ~clk;

   gem_link_sequencer #(
      .PLLRST_CYC(P_PLL), .GTXRST_CYC(P_GTX), .COMMA_CYC(P_COMMA),
      .TIMEOUT_CYC(P_TO), .FIFO_AW(2)
   ) dut (
      .TRG_CLK80(clk), .RST(rst), .TX_PLL_LOCK(lock), .TXRESETDONE(done),
      .TX_SYNC_DONE(sync), .TRG_TX_PLLRST(pllrst), .TRG_GTXTXRST(gtxrst),
      .TRG_RST(trg_rst), .CLU_DATA(clu_data), .CLU_VALID(clu_valid),
      .CLU_READY(clu_ready), .GEM_DATA(gem_data), .FRM_SEP(frm_sep),
      .GEM_OVERFLOW(gem_ovf), .LINK_UP(link_up), .STATE(state), .ERR_CNT(err_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: states by number, time spent in state, queue of words.
   int          m_state, m_cnt, m_err, m_kidx;
   bit          m_ph, m_ovf, m_acc;
   logic [55:0] m_q[$];
   logic [55:0] m_gem;
   logic [7:0]  m_sep;
   logic [7:0]  kseq [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};

   task automatic model_flush();
      m_q.delete();
      m_ph = 0; m_kidx = 0; m_gem = '0; m_sep = 8'hBC; m_ovf = 0; m_acc = 0;
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 1; m_err = 0;
      model_flush();
   endtask

   task automatic model_step();
      int nxt;
      bit err, ready, evt;
      nxt = m_state; err = 0;
      if (m_state >= 2 && !lock) begin nxt = 0; err = 1; end
      else begin
         case (m_state)
            0: if (m_cnt == P_PLL) nxt = 1;
            1: if (lock) nxt = 2; else if (m_cnt == P_TO) begin nxt = 0; err = 1; end
            2: if (m_cnt == P_GTX) nxt = 3;
            3: if (done && sync) nxt = 4; else if (m_cnt == P_TO) begin nxt = 0; err = 1; end
            4: if (m_cnt == P_COMMA) nxt = 5;
            default: ;
         endcase
      end
      if (err && m_err < 255) m_err++;
      if (nxt != 5) model_flush();
      else if (m_state == 5) begin
         ready = (m_q.size() < DEPTH);
         evt   = clu_valid && !ready;
         if (m_ph) begin
            m_gem = (m_q.size() > 0) ? m_q.pop_front() : 56'h0;
            m_sep = kseq[m_kidx];
            m_kidx = (m_kidx + 1) % 4;
            m_ovf = m_acc | evt;
            m_acc = 0;
         end else begin
            m_acc = m_acc | evt;
         end
         if (clu_valid && ready) m_q.push_back(clu_data);
         m_ph = !m_ph;
      end
      m_cnt = (nxt != m_state) ? 1 : m_cnt + 1;
      m_state = nxt;
   endtask

   task automatic compare_all();
      chk("state", 64'(state), 64'(m_state));
      chk("rst_ctl", 64'({pllrst, gtxrst, trg_rst}),
          64'({m_state == 0, m_state <= 2, m_state != 5}));
      chk("link_up", 64'(link_up), 64'(m_state == 5));
      chk("clu_ready", 64'(clu_ready), 64'(m_state == 5 && m_q.size() < DEPTH));
      chk("gem_data", 64'(gem_data), 64'(m_gem));
      chk("frm_sep", 64'(frm_sep), 64'(m_sep));
      chk("gem_ovf", 64'(gem_ovf), 64'(m_ovf));
      chk("err_cnt", 64'(err_cnt), 64'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic [55:0] rnd56();
      return 56'({$urandom(), $urandom()});
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] seq;
      logic [2:0]  last;
      int comma_cnt, a_cnt, b_cnt;
      bit saw_full, saw_ovf;
      logic [55:0] wa, wb;

      rst = 1; lock = 0; done = 0; sync = 0; clu_valid = 0; clu_data = '0;
      model_reset();
      repeat (3) tick();
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_frm_sep", 64'(frm_sep), 64'hBC);
      chk("rst_ctl_ones", 64'({pllrst, gtxrst, trg_rst}), 64'd7);
      rst = 0;

      // Normal bring-up: lock at 20, reset-done and sync at 40.
      seq = '0; last = 3'd0; comma_cnt = 0;
      for (int c = 0; c < 300; c++) begin
         lock = (c >= 20); done = (c >= 40); sync = (c >= 40);
         tick();
         if (state != last) begin seq = {seq[14:0], state}; last = state; end
         if (state == 3'd4) comma_cnt++;
         if (state == 3'd5) break;
      end
      chk("reach_run", 64'(state), 64'd5);
      chk("bringup_seq", 64'(seq), 64'(18'o012345));
      chk("comma_len", 64'(comma_cnt), 64'd64);
      chk("run_trg_rst", 64'(trg_rst), 64'd0);
      chk("run_link_up", 64'(link_up), 64'd1);
      chk("run_err_cnt", 64'(err_cnt), 64'd0);

      // Back-to-back words, each must be held for one full frame.
      wa = 56'hA0A1A2A3A4A5A6; wb = 56'hB0B1B2B3B4B5B6;
      a_cnt = 0; b_cnt = 0;
      clu_valid = 1; clu_data = wa; tick();
      clu_data = wb; tick();
      clu_valid = 0; clu_data = '0;
      for (int c = 0; c < 12; c++) begin
         if (gem_data == wa) a_cnt++;
         if (gem_data == wb) b_cnt++;
         tick();
      end
      chk("word_a_cycles", 64'(a_cnt), 64'd2);
      chk("word_b_cycles", 64'(b_cnt), 64'd2);
      chk("empty_frame_zero", 64'(gem_data), 64'd0);

      // Random traffic with the link up.
      for (int c = 0; c < 400; c++) begin
         clu_valid = ($urandom_range(0, 2) == 0); clu_data = rnd56();
         tick();
      end

      // Overflow: valid held for 12 cycles from an empty FIFO.
      clu_valid = 0; repeat (10) tick();
      saw_full = 0; saw_ovf = 0;
      for (int c = 0; c < 12; c++) begin
         clu_valid = 1; clu_data = rnd56();
         tick();
         if (!clu_ready) saw_full = 1;
         if (gem_ovf) saw_ovf = 1;
      end
      clu_valid = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (gem_ovf) saw_ovf = 1;
      end
      chk("ovf_full_seen", 64'(saw_full), 64'd1);
      chk("ovf_flag_seen", 64'(saw_ovf), 64'd1);
      chk("ovf_cleared", 64'(gem_ovf), 64'd0);

      // Lock loss with a full FIFO.
      for (int c = 0; c < 6; c++) begin clu_valid = 1; clu_data = rnd56(); tick(); end
      lock = 0; clu_valid = 0;
      tick();
      chk("loss_state", 64'(state), 64'd0);
      chk("loss_gem_data", 64'(gem_data), 64'd0);
      chk("loss_frm_sep", 64'(frm_sep), 64'hBC);
      chk("loss_trg_rst", 64'(trg_rst), 64'd1);
      chk("loss_err_cnt", 64'(err_cnt), 64'd1);

      // Random status and traffic.
      for (int c = 0; c < 1500; c++) begin
         lock = ($urandom_range(0, 299) != 0);
         done = $urandom_range(0, 1); sync = $urandom_range(0, 1);
         clu_valid = $urandom_range(0, 1); clu_data = rnd56();
         tick();
      end

      // Lock never comes: timeouts drive ERR_CNT into saturation.
      lock = 0; clu_valid = 0;
      repeat (256 * (P_PLL + P_TO) + 50) tick();
      chk("err_saturated", 64'(err_cnt), 64'hFF);

      // Bring up again and reset asynchronously mid-frame.
      lock = 1; done = 1; sync = 1;
      for (int c = 0; c < 120; c++) begin
         clu_valid = $urandom_range(0, 1); clu_data = rnd56();
         tick();
      end
      chk("pre_rst_run", 64'(state), 64'd5);
      clu_valid = 1;
      #2 rst = 1;
      #1;
      chk("arst_state", 64'(state), 64'd0);
      chk("arst_ctl", 64'({pllrst, gtxrst, trg_rst}), 64'd7);
      chk("arst_ready_link", 64'({clu_ready, link_up}), 64'd0);
      chk("arst_gem_data", 64'(gem_data), 64'd0);
      chk("arst_frm_sep", 64'(frm_sep), 64'hBC);
      chk("arst_ovf", 64'(gem_ovf), 64'd0);
      chk("arst_err_cnt", 64'(err_cnt), 64'd0);
      model_reset();
      tick();
      rst = 0; clu_valid = 0;
      repeat (20) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
